// File: rtl/hdmi_pkg.sv
// Shared widths, lane layout, FSM encoding and beat payload for the HDMI capture path.
package hdmi_pkg;

  localparam int unsigned PIXEL_W     = 24;
  localparam int unsigned LANE_W      = 32;
  localparam int unsigned COORD_W     = 10;
  localparam int unsigned TDATA_W     = 2 * LANE_W;
  localparam int unsigned BEAT_W      = TDATA_W + 2;
  localparam int unsigned LANE_LO_OFS = 0;
  localparam int unsigned LANE_HI_OFS = LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DROP    = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic               user;
    logic               last;
    logic [TDATA_W-1:0] data;
  } beat_t;

  // Zero-extend a 24-bit RGB pixel into a 32-bit lane.
  function automatic logic [LANE_W-1:0] to_lane(input logic [PIXEL_W-1:0] px);
    return LANE_W'(px);
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock stream FIFO; flop storage, full/empty from extra-bit pointers.
module axis_sync_fifo #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty_c;
  logic             pop_c;
  logic             wr_en_c;

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid_o = !empty_c;
  assign pop_c   = ready_i && !empty_c;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_en_c = push_i && (!full_o || pop_c);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage array; cleared on reset so the output bus reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_en_c) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_c)   rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/hdmi_capture_packer.sv
// Samples a timed raster, packs two pixels per 64-bit beat and queues beats for AXI-Stream.
module hdmi_capture_packer
  import hdmi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] screen_width,
  input  logic [COORD_W-1:0] screen_height,
  input  logic [PIXEL_W-1:0] rgb,
  output logic [TDATA_W-1:0] m_axis_rgb_tdata,
  output logic               m_axis_rgb_tvalid,
  input  logic               m_axis_rgb_tready,
  output logic               m_axis_rgb_tlast,
  output logic               m_axis_rgb_tuser,
  input  logic               overflow_clr,
  output logic               overflow
);

  logic               s1_vld_q;
  logic [COORD_W-1:0] cx_q;
  logic [COORD_W-1:0] cy_q;
  logic [PIXEL_W-1:0] rgb_q;

  cap_state_e         state_q, state_d;
  logic [PIXEL_W-1:0] hold_q, hold_d;
  logic               overflow_q;

  logic               active_c;
  logic               frame_start_c;
  logic               last_px_c;
  logic               proc_c;
  logic               push_c;
  logic               drop_c;
  beat_t              beat_c;
  beat_t              out_beat;
  logic               fifo_full;
  logic               fifo_valid;

  // Stage 1: register the raster inputs; s1_vld_q keeps post-reset zeros from looking like (0,0).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_vld_q <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      rgb_q    <= '0;
    end else begin
      s1_vld_q <= 1'b1;
      cx_q     <= cx;
      cy_q     <= cy;
      rgb_q    <= rgb;
    end
  end

  assign active_c      = (cx_q < screen_width) && (cy_q < screen_height);
  assign frame_start_c = s1_vld_q && (cx_q == '0) && (cy_q == '0);
  assign last_px_c     = (cx_q == screen_width - COORD_W'(1));

  // Stage 2 state: FSM, low-lane holding register, sticky overflow.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      overflow_q <= drop_c | (overflow_q & ~overflow_clr);
    end
  end

  // Next state and packer: even pixels load the holding register, odd pixels (or an odd-width tail) push.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    proc_c  = 1'b0;
    push_c  = 1'b0;
    drop_c  = 1'b0;
    beat_c  = '0;

    unique case (state_q)
      ST_IDLE, ST_DROP: proc_c = frame_start_c;
      ST_CAPTURE:       proc_c = s1_vld_q;
      default:          proc_c = 1'b0;
    endcase

    if (proc_c) begin
      state_d = ST_CAPTURE;
      if (active_c) begin
        if (!cx_q[0]) begin
          hold_d = rgb_q;
          if (last_px_c) begin
            push_c = 1'b1;
            beat_c.data[LANE_LO_OFS +: LANE_W] = to_lane(rgb_q);
            beat_c.last = 1'b1;
          end
        end else begin
          push_c = 1'b1;
          beat_c.data[LANE_LO_OFS +: LANE_W] = to_lane(hold_q);
          beat_c.data[LANE_HI_OFS +: LANE_W] = to_lane(rgb_q);
          beat_c.last = last_px_c;
          beat_c.user = (cy_q == '0) && (cx_q == COORD_W'(1));
        end
      end
      // A beat lost to a full FIFO abandons the rest of the frame.
      if (push_c && fifo_full && !(fifo_valid && m_axis_rgb_tready)) begin
        drop_c  = 1'b1;
        state_d = ST_DROP;
      end
    end
  end

  axis_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .push_i  (push_c),
    .din_i   (beat_c),
    .ready_i (m_axis_rgb_tready),
    .dout_o  (out_beat),
    .valid_o (fifo_valid),
    .full_o  (fifo_full)
  );

  assign m_axis_rgb_tdata  = out_beat.data;
  assign m_axis_rgb_tlast  = out_beat.last;
  assign m_axis_rgb_tuser  = out_beat.user;
  assign m_axis_rgb_tvalid = fifo_valid;
  assign overflow          = overflow_q;

endmodule
